// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU data-bus responder slice.
// Holds the FSM state encoding, the work-RAM region decode and the open-bus reset value.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } bus_state_t;

  localparam logic [15:0] RAM_REGION_MASK = 16'hE000;
  localparam logic [15:0] RAM_REGION_BASE = 16'h0000;
  localparam logic [7:0]  OPEN_BUS_RESET  = 8'h00;

  // Work RAM occupies $0000-$1FFF; everything else falls to the open-bus path.
  function automatic logic is_ram_hit(input logic [15:0] address);
    return (address & RAM_REGION_MASK) == RAM_REGION_BASE;
  endfunction

endpackage

// File: rtl/cpu_bus_if.sv
// CPU data-bus request/response signals between the CPU core and the bus responder.
// Signal names keep the responder-side direction suffixes so both ends read the same.
interface cpu_bus_if;

  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        write_i;
  logic        request_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        data_valid_o;

  modport master (
    output address_i, data_i, write_i, request_i,
    input  ready_o, data_o, data_valid_o
  );

  modport slave (
    input  address_i, data_i, write_i, request_i,
    output ready_o, data_o, data_valid_o
  );

endinterface

// File: rtl/work_ram.sv
// Single-port synchronous work RAM, 2**ADDRESS_WIDTH bytes.
// Read data appears the cycle after the address is presented; a write returns the old byte.
module work_ram #(
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock_i,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [7:0]               write_data,
  output logic [7:0]               read_data
);

  logic [7:0] mem [2**ADDRESS_WIDTH];

  // NOTE: no reset on the array so it maps onto block RAM; contents survive a bus reset.
  always_ff @(posedge clock_i) begin
    if (write_enable) begin
      mem[address] <= write_data;
    end
    read_data <= mem[address];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU data-bus target: one transaction at a time, mirrored 2 KiB work RAM below $2000,
// open-bus answers elsewhere, and a one-cycle completion pulse after a fixed latency.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int RESPONSE_LATENCY  = 2,
  parameter int RAM_ADDRESS_WIDTH = 11
) (
  input  logic      clock_i,
  input  logic      reset_n_i,
  cpu_bus_if.slave  bus
);

  localparam int COUNT_WIDTH = $clog2(RESPONSE_LATENCY + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(RESPONSE_LATENCY - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  bus_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [15:0] address_q;
  logic [7:0]  write_data_q;
  logic        write_q;
  logic        issue_q;
  logic [7:0]  open_bus_q;
  logic [7:0]  data_hold_q;

  logic        ready;
  logic        accept;
  logic        ram_hit;
  logic        ram_write_enable;
  logic [7:0]  ram_read_data;
  logic [7:0]  response_data;

  // The response cycle also accepts, so back-to-back transfers run every LATENCY+1 cycles.
  assign ready   = (state_q == IDLE) || (state_q == RESPOND);
  assign accept  = bus.request_i && ready;
  assign ram_hit = is_ram_hit(address_q);

  // Write commits (and read issues) on the first edge after acceptance.
  assign ram_write_enable = issue_q && write_q && ram_hit;

  work_ram #(
    .ADDRESS_WIDTH (RAM_ADDRESS_WIDTH)
  ) u_work_ram (
    .clock_i      (clock_i),
    .write_enable (ram_write_enable),
    .address      (address_q[RAM_ADDRESS_WIDTH-1:0]),
    .write_data   (write_data_q),
    .read_data    (ram_read_data)
  );

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          count_d = COUNT_LOAD;
        end
      end
      WAIT: begin
        if (count_q == '0) begin
          state_d = RESPOND;
        end else begin
          count_d = count_q - COUNT_ONE;
        end
      end
      RESPOND: begin
        if (accept) begin
          state_d = WAIT;
          count_d = COUNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    response_data = open_bus_q;
    if (write_q) begin
      response_data = write_data_q;
    end else if (ram_hit) begin
      response_data = ram_read_data;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      write_q      <= 1'b0;
      issue_q      <= 1'b0;
      open_bus_q   <= OPEN_BUS_RESET;
      data_hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      issue_q <= accept;
      if (accept) begin
        address_q    <= bus.address_i;
        write_data_q <= bus.data_i;
        write_q      <= bus.write_i;
      end
      if (state_q == RESPOND) begin
        data_hold_q <= response_data;
        // Unmapped reads leave the latch alone; everything else refreshes it.
        if (write_q || ram_hit) begin
          open_bus_q <= response_data;
        end
      end
    end
  end

  assign bus.ready_o      = ready;
  assign bus.data_valid_o = (state_q == RESPOND);
  assign bus.data_o       = (state_q == RESPOND) ? response_data : data_hold_q;

endmodule
